imm_extend_pipe: RTL and testbench

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

---
 rtl/imm_ext_pkg.sv | 14 +
 rtl/imm_ext_skid.sv | 57 +++++
 rtl/imm_extend_pipe.sv | 77 +++++++
 tb/tb_imm_extend_pipe.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension pipe: mode encoding and default widths.
package imm_ext_pkg;

    localparam int IMM_IN_W_DEF  = 16;
    localparam int IMM_OUT_W_DEF = 32;

    typedef enum logic [1:0] {
        SEXT  = 2'd0,
        ZEXT  = 2'd1,
        UPPER = 2'd2,
        BRSH  = 2'd3
    } imm_mode_t;

endpackage

// File: rtl/imm_ext_skid.sv
// Two-entry output buffer (main register + one skid entry).
// in_ready depends only on local state, so out_ready never reaches it combinationally.
module imm_ext_skid #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             r_main_valid;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_main_data;
    logic [WIDTH-1:0] r_skid_data;
    logic             w_accept;
    logic             w_drain;

    assign in_ready  = !r_skid_valid;
    assign out_valid = r_main_valid;
    assign out_data  = r_main_data;

    assign w_accept = in_valid && !r_skid_valid;
    assign w_drain  = r_main_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_data  <= '0;
        end else begin
            // The skid entry is only ever occupied while the main register is full.
            if (r_skid_valid) begin
                if (out_ready) begin
                    r_main_data  <= r_skid_data;
                    r_skid_valid <= 1'b0;
                end
            end else if (w_accept) begin
                if (!r_main_valid || out_ready) begin
                    r_main_data  <= in_data;
                    r_main_valid <= 1'b1;
                end else begin
                    r_skid_data  <= in_data;
                    r_skid_valid <= 1'b1;
                end
            end else if (w_drain) begin
                r_main_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate extender (SEXT/ZEXT/UPPER/BRSH) followed by a registered 2-entry skid buffer.
// Define IMM_EXTEND_PIPE_BRSH_EN to enable mode 3 (BRSH); otherwise mode 3 is flagged illegal.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = IMM_IN_W_DEF,
    parameter int OUT_W = IMM_OUT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm,
    output logic             out_err
);

    localparam int EXT_W = OUT_W - IN_W;

    generate
        if (OUT_W < IN_W + 2) begin : g_width_check
            $error("imm_extend_pipe: OUT_W must be at least IN_W+2");
        end
    endgenerate

    logic [OUT_W-1:0] w_sext;
    logic [OUT_W-1:0] w_zext;
    logic [OUT_W-1:0] w_upper;
    logic [OUT_W-1:0] w_ext_imm;
    logic             w_ext_err;
    logic [OUT_W:0]   w_skid_out;

    assign w_sext  = {{EXT_W{in_imm[IN_W-1]}}, in_imm};
    assign w_zext  = {{EXT_W{1'b0}}, in_imm};
    assign w_upper = {in_imm, {EXT_W{1'b0}}};

`ifdef IMM_EXTEND_PIPE_BRSH_EN
    logic [OUT_W-1:0] w_brsh;
    assign w_brsh = {w_sext[OUT_W-3:0], 2'b00};
`endif

    always_comb begin
        w_ext_imm = '0;
        w_ext_err = 1'b0;
        case (imm_mode_t'(in_mode))
            SEXT:  w_ext_imm = w_sext;
            ZEXT:  w_ext_imm = w_zext;
            UPPER: w_ext_imm = w_upper;
`ifdef IMM_EXTEND_PIPE_BRSH_EN
            BRSH:  w_ext_imm = w_brsh;
`else
            BRSH:  w_ext_err = 1'b1;
`endif
            default: w_ext_err = 1'b1;
        endcase
    end

    imm_ext_skid #(
        .WIDTH (OUT_W + 1)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({w_ext_err, w_ext_imm}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_skid_out)
    );

    assign out_err = w_skid_out[OUT_W];
    assign out_imm = w_skid_out[OUT_W-1:0];

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: vector table, backpressure, random traffic, reset.
module tb_imm_extend_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic        out_err;

    int n_tests = 0;
    int n_fail  = 0;
    int n_drained = 0;
    logic [32:0] exp_q[$];

    imm_extend_pipe #(
        .IN_W  (16),
        .OUT_W (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] imm;
        logic [1:0]  mode;
        logic [31:0] exp_imm;
        logic        exp_err;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("[TB] ok %s: 0x%0h", name, act);
        end
    endtask

    // Reference model: {err, imm}
    function automatic logic [32:0] model(input logic [15:0] imm, input logic [1:0] mode);
        logic signed [31:0] s;
        logic [31:0] b;
        s = $signed(imm);
        b = s <<< 2;
        case (mode)
            2'd0: model = {1'b0, s};
            2'd1: model = {1'b0, 16'h0000, imm};
            2'd2: model = {1'b0, imm, 16'h0000};
`ifdef IMM_EXTEND_PIPE_BRSH_EN
            default: model = {1'b0, b};
`else
            default: model = {1'b1, 32'h0};
`endif
        endcase
    endfunction

    // One clock cycle with scoreboard bookkeeping; inputs are already driven.
    task automatic step(output bit acc);
        bit          drn;
        bit          hold;
        logic [32:0] held;
        logic [32:0] e;
        acc  = in_valid && in_ready;
        drn  = out_valid && out_ready;
        hold = out_valid && !out_ready;
        held = {out_err, out_imm};
        if (drn) begin
            n_drained++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_beat: got 0x%0h expected none", held);
            end else begin
                e = exp_q.pop_front();
                n_tests++;
                if (held !== e) begin
                    n_fail++;
                    $display("FAIL beat: got 0x%0h expected 0x%0h", held, e);
                end
            end
        end
        if (acc) exp_q.push_back(model(in_imm, in_mode));
        @(posedge clk);
        #1;
        if (hold) begin
            n_tests++;
            if ({out_valid, out_err, out_imm} !== {1'b1, held}) begin
                n_fail++;
                $display("FAIL hold: got 0x%0h expected 0x%0h", {out_valid, out_err, out_imm}, {1'b1, held});
            end
        end
    endtask

    initial begin
        vec_t vecs[10];
        bit   acc;
        int   nacc;
        int   cyc;
        int   sent;

        vecs[0] = '{16'h8004, 2'd0, 32'hFFFF8004, 1'b0};
        vecs[1] = '{16'h8004, 2'd1, 32'h00008004, 1'b0};
        vecs[2] = '{16'h8004, 2'd2, 32'h80040000, 1'b0};
        vecs[3] = '{16'h7FFF, 2'd0, 32'h00007FFF, 1'b0};
        vecs[4] = '{16'hFFFF, 2'd1, 32'h0000FFFF, 1'b0};
        vecs[5] = '{16'h0001, 2'd2, 32'h00010000, 1'b0};
        vecs[6] = '{16'h0000, 2'd0, 32'h00000000, 1'b0};
`ifdef IMM_EXTEND_PIPE_BRSH_EN
        vecs[7] = '{16'hFFFF, 2'd3, 32'hFFFFFFFC, 1'b0};
        vecs[8] = '{16'h0001, 2'd3, 32'h00000004, 1'b0};
        vecs[9] = '{16'h8000, 2'd3, 32'hFFFE0000, 1'b0};
`else
        vecs[7] = '{16'hFFFF, 2'd3, 32'h00000000, 1'b1};
        vecs[8] = '{16'h0001, 2'd3, 32'h00000000, 1'b1};
        vecs[9] = '{16'h8000, 2'd3, 32'h00000000, 1'b1};
`endif

        rst = 1'b1;
        in_valid = 1'b0;
        in_imm = '0;
        in_mode = '0;
        out_ready = 1'b0;

        // Reset state
        @(posedge clk);
        #1;
        check("reset_outputs", {out_valid, out_err, out_imm}, 34'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1);

        // Vector table, out_ready held high: each result appears one cycle later
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_imm   = vecs[i].imm;
            in_mode  = vecs[i].mode;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check($sformatf("vec%0d", i), {out_valid, out_err, out_imm},
                  {1'b1, vecs[i].exp_err, vecs[i].exp_imm});
        end
        @(posedge clk);
        #1;
        check("vec_drained", out_valid, 0);

        // Backpressure: beats 1..4, out_ready low for 3 cycles
        exp_q.delete();
        n_drained = 0;
        nacc = 0;
        out_ready = 1'b0;
        in_mode = 2'd1;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_imm = 16'(nacc + 1);
            step(acc);
            if (acc) nacc++;
        end
        check("bp_accepted", nacc, 2);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_main_head", {out_valid, out_imm}, {1'b1, 32'h1});
        out_ready = 1'b1;
        cyc = 0;
        while ((nacc < 4 || exp_q.size() != 0) && cyc < 20) begin
            in_valid = (nacc < 4);
            in_imm = 16'(nacc + 1);
            step(acc);
            if (acc) nacc++;
            cyc++;
        end
        in_valid = 1'b0;
        check("bp_drained", n_drained, 4);

        // Full rate with out_ready high
        n_drained = 0;
        nacc = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            in_imm = 16'(16'hA000 + c);
            in_mode = 2'(c % 3);
            step(acc);
            if (acc) nacc++;
        end
        in_valid = 1'b0;
        step(acc);
        step(acc);
        check("rate_accepted", nacc, 8);
        check("rate_drained", n_drained, 8);

        // Random valid/ready toggling with scoreboard
        exp_q.delete();
        n_drained = 0;
        sent = 0;
        cyc = 0;
        while ((sent < 10000 || exp_q.size() != 0) && cyc < 60000) begin
            in_valid  = (sent < 10000) && ($urandom_range(3) != 0);
            in_imm    = 16'($urandom);
            in_mode   = 2'($urandom_range(3));
            out_ready = ($urandom_range(3) != 0);
            step(acc);
            if (acc) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        check("rand_sent", sent, 10000);
        check("rand_drained", n_drained, 10000);

        // Reset with two beats buffered
        exp_q.delete();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_mode = 2'd1;
        @(posedge clk);
        #1;
        in_imm = 16'h1111;
        @(posedge clk);
        #1;
        in_imm = 16'h2222;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("rst_pre_full", {out_valid, in_ready}, 2'b10);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", {out_valid, out_err, out_imm, in_ready}, {1'b0, 1'b0, 32'h0, 1'b1});
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        check("rst_after_release", {out_valid, in_ready}, 2'b01);
        in_valid = 1'b1;
        in_imm = 16'h3333;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("rst_first_beat", {out_valid, out_err, out_imm}, {1'b1, 1'b0, 32'h3333});
        @(posedge clk);
        #1;
        check("rst_no_stale", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
